cpu_exu_seq: RTL and testbench
==============================

Name: cpu_exu_seq

Overview:
Execution-stage sequencer placed between the issue logic and cpu_exu. It accepts one operation at a time through a valid/ready handshake and latches the operands. It holds the EXU inputs stable for the operation's class latency and drives the EXU wait/flush controls. It then captures the EXU result and presents it to writeback through a valid/ready handshake, which lets multi-cycle FP units (div/sqrt) share the single EXU.

Parameters:
INT_LAT, 1, cycles EXU inputs are held for fp_ctrl=INT (min 1)
FP_LAT, 2, cycles held for FP_S/FP_D non-div/sqrt ops (min 1)
FPDIV_LAT, 12, cycles held for FP div/sqrt ops (min 1, max 255)
ALU_FDIV, 5'd12, alu_ctrl code of FP divide
ALU_FSQRT, 5'd13, alu_ctrl code of FP square root

Ports:
clk  in  1  clock
rst  in  1  asynchronous reset, active-high
flush_in  in  1  pipeline flush request
req_valid  in  1  issue request valid
req_ready  out  1  sequencer can accept an op
req_fp_ctrl  in  2  00 INT, 01 FP_S, 10 FP_D, 11 illegal
req_alu_ctrl  in  5  ALU operation code
req_in1/req_in2/req_in3  in  64 each  operands
exu_fp_ctrl  out  2  to cpu_exu fp_ctrl
exu_alu_ctrl  out  5  to cpu_exu alu_ctrl
exu_in1/exu_in2/exu_in3  out  64 each  to cpu_exu operands
exu_wait  out  1  to cpu_exu wait_exe
exu_flush  out  1  to cpu_exu flush_flag
exu_out  in  64  registered result from cpu_exu
res_valid  out  1  result available
res_ready  in  1  writeback accepts result
res_data  out  64  result
op_count  out  32  completed-op counter, wraps at 2^32

Behaviour:
- Reset (async, rst=1) clears everything:
  - state=IDLE; exu_* operand/ctrl regs=0; exu_wait=1.
  - res_valid=0; res_data=0; op_count=0; down-counter=0.
- exu_flush = flush_in (combinational pass-through).
- req_ready = (state==IDLE) && !flush_in.
- Latency select at accept:
  - fp_ctrl=INT -> INT_LAT.
  - fp_ctrl FP_S/FP_D with alu_ctrl == ALU_FDIV or ALU_FSQRT -> FPDIV_LAT.
  - other FP -> FP_LAT.
  - fp_ctrl=11 -> INT_LAT; cpu_exu then yields 0, and the result is 0.
- States:
  - IDLE: exu_wait=1.
    - On req_valid&&req_ready: latch fp_ctrl/alu_ctrl/operands into exu_* regs, load cnt=lat-1, go EXEC.
  - EXEC: exu_wait=0; exu_* held stable.
    - cnt!=0 -> cnt-=1.
    - cnt==0 -> go WB.
  - WB (1 cycle): exu_wait=0; capture exu_out into res_data; go DONE.
    - exu_out in this cycle reflects the final EXEC cycle's inputs.
  - DONE: exu_wait=1; res_valid=1; res_data held stable.
    - res_valid&&res_ready -> op_count+=1, go IDLE.
- Latency: accept edge to res_valid high = lat+2 cycles. Throughput is one op per lat+3 cycles minimum, because there is no accept in DONE.
- exu_* operand/ctrl regs keep their last values outside EXEC. They are don't-care to cpu_exu while exu_wait=1.
- Flush handling:
  - flush_in=1 in any state -> next state IDLE, res_valid=0 next cycle, op_count unchanged, no result delivered.
  - Flush has priority over accept, countdown, capture and res handshake. A res_ready coinciding with flush does not count.
- res_valid never drops without a res_ready handshake except on flush or reset.
- Reset asserted mid-operation aborts immediately; no partial result is retained.

Test Plan:
- INT add: req fp_ctrl=00, alu_ctrl=ADD, in1=5, in2=7, res_ready=1. Accept at cycle 0 -> exu_wait low cycles 1-2, res_valid at cycle 3 with res_data=exu_out value 12, op_count=1, req_ready high again at cycle 4.
- FP div: fp_ctrl=01, alu_ctrl=12 -> exu_in* stable for 12 EXEC cycles, res_valid exactly 14 cycles after accept; FP add (alu_ctrl!=12/13) -> res_valid 4 cycles after accept.
- Backpressure: res_ready=0 for 5 cycles after res_valid -> res_data stable, exu_wait=1, req_ready=0 throughout, and a pending req_valid is not accepted. Raising res_ready -> handshake, op_count+1.
- Flush during EXEC of FP div at cycle 6 -> IDLE next cycle, res_valid never asserts, op_count unchanged, exu_flush mirrors flush_in. Flush with req_valid in IDLE -> not accepted.
- Async reset in DONE with res_valid=1 -> res_valid=0, res_data=0, op_count=0 immediately, without waiting for a clk edge.
- op_count preloaded near wrap via 2^32 handshakes (or forced) -> 0xFFFFFFFF +1 -> 0.

Source files
------------

// File: rtl/cpu_exu_seq.sv
// Execution-stage sequencer: latches one op, holds cpu_exu inputs for the
// op-class latency, captures the result and offers it to writeback.
module cpu_exu_seq #(
   parameter int unsigned INT_LAT   = 1,
   parameter int unsigned FP_LAT    = 2,
   parameter int unsigned FPDIV_LAT = 12,
   parameter logic [4:0]  ALU_FDIV  = 5'd12,
   parameter logic [4:0]  ALU_FSQRT = 5'd13
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        flush_in,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic [1:0]  req_fp_ctrl,
   input  logic [4:0]  req_alu_ctrl,
   input  logic [63:0] req_in1,
   input  logic [63:0] req_in2,
   input  logic [63:0] req_in3,
   output logic [1:0]  exu_fp_ctrl,
   output logic [4:0]  exu_alu_ctrl,
   output logic [63:0] exu_in1,
   output logic [63:0] exu_in2,
   output logic [63:0] exu_in3,
   output logic        exu_wait,
   output logic        exu_flush,
   input  logic [63:0] exu_out,
   output logic        res_valid,
   input  logic        res_ready,
   output logic [63:0] res_data,
   output logic [31:0] op_count
);

   typedef enum logic [1:0] {
      IDLE,
      EXEC,
      WB,
      DONE
   } state_t;

   localparam logic [7:0] INT_M1   = 8'(INT_LAT - 1);
   localparam logic [7:0] FP_M1    = 8'(FP_LAT - 1);
   localparam logic [7:0] FPDIV_M1 = 8'(FPDIV_LAT - 1);

   state_t      state_q;
   logic [7:0]  cnt_q;
   logic [1:0]  fp_q;
   logic [4:0]  alu_q;
   logic [63:0] in1_q;
   logic [63:0] in2_q;
   logic [63:0] in3_q;
   logic        wait_q;
   logic        rv_q;
   logic [63:0] data_q;
   logic [31:0] op_count_q;
   logic [7:0]  lat_d;
   logic        is_fp;
   logic        is_div;

   assign is_fp  = (req_fp_ctrl == 2'b01) || (req_fp_ctrl == 2'b10);
   assign is_div = (req_alu_ctrl == ALU_FDIV) || (req_alu_ctrl == ALU_FSQRT);

   // Illegal fp_ctrl (11) takes the integer latency.
   always_comb begin
      lat_d = INT_M1;
      if (is_fp && is_div) begin
         lat_d = FPDIV_M1;
      end else if (is_fp) begin
         lat_d = FP_M1;
      end
   end

   assign req_ready    = (state_q == IDLE) && !flush_in;
   assign exu_flush    = flush_in;
   assign exu_fp_ctrl  = fp_q;
   assign exu_alu_ctrl = alu_q;
   assign exu_in1      = in1_q;
   assign exu_in2      = in2_q;
   assign exu_in3      = in3_q;
   assign exu_wait     = wait_q;
   assign res_valid    = rv_q;
   assign res_data     = data_q;
   assign op_count     = op_count_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= IDLE;
         cnt_q      <= '0;
         fp_q       <= '0;
         alu_q      <= '0;
         in1_q      <= '0;
         in2_q      <= '0;
         in3_q      <= '0;
         wait_q     <= 1'b1;
         rv_q       <= 1'b0;
         data_q     <= '0;
         op_count_q <= '0;
      end else if (flush_in) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         wait_q  <= 1'b1;
         rv_q    <= 1'b0;
      end else begin
         unique case (state_q)
            IDLE: begin
               if (req_valid) begin
                  fp_q    <= req_fp_ctrl;
                  alu_q   <= req_alu_ctrl;
                  in1_q   <= req_in1;
                  in2_q   <= req_in2;
                  in3_q   <= req_in3;
                  cnt_q   <= lat_d;
                  wait_q  <= 1'b0;
                  state_q <= EXEC;
               end
            end
            EXEC: begin
               if (cnt_q != 8'd0) begin
                  cnt_q <= cnt_q - 8'd1;
               end else begin
                  state_q <= WB;
               end
            end
            WB: begin
               data_q  <= exu_out;
               rv_q    <= 1'b1;
               wait_q  <= 1'b1;
               state_q <= DONE;
            end
            DONE: begin
               if (res_ready) begin
                  rv_q       <= 1'b0;
                  op_count_q <= op_count_q + 32'd1;
                  state_q    <= IDLE;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_cpu_exu_seq.sv
// Scoreboard bench for cpu_exu_seq with a behavioural cpu_exu stand-in.
module tb_cpu_exu_seq;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        flush_in = 1'b0;
   logic        req_valid = 1'b0;
   logic        req_ready;
   logic [1:0]  req_fp_ctrl = '0;
   logic [4:0]  req_alu_ctrl = '0;
   logic [63:0] req_in1 = '0;
   logic [63:0] req_in2 = '0;
   logic [63:0] req_in3 = '0;
   logic [1:0]  exu_fp_ctrl;
   logic [4:0]  exu_alu_ctrl;
   logic [63:0] exu_in1;
   logic [63:0] exu_in2;
   logic [63:0] exu_in3;
   logic        exu_wait;
   logic        exu_flush;
   logic [63:0] exu_out = '0;
   logic        res_valid;
   logic        res_ready = 1'b0;
   logic [63:0] res_data;
   logic [31:0] op_count;

   cpu_exu_seq dut (
      .clk(clk), .rst(rst), .flush_in(flush_in),
      .req_valid(req_valid), .req_ready(req_ready),
      .req_fp_ctrl(req_fp_ctrl), .req_alu_ctrl(req_alu_ctrl),
      .req_in1(req_in1), .req_in2(req_in2), .req_in3(req_in3),
      .exu_fp_ctrl(exu_fp_ctrl), .exu_alu_ctrl(exu_alu_ctrl),
      .exu_in1(exu_in1), .exu_in2(exu_in2), .exu_in3(exu_in3),
      .exu_wait(exu_wait), .exu_flush(exu_flush), .exu_out(exu_out),
      .res_valid(res_valid), .res_ready(res_ready),
      .res_data(res_data), .op_count(op_count)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [63:0] d;
      int          lat;
      int          acc;
   } exp_t;

   exp_t        sb[$];
   int          total = 0;
   int          bad = 0;
   int          cyc = 0;
   logic [31:0] exp_cnt = '0;
   logic        rnd_rdy = 1'b0;
   logic        rv_prev = 1'b0;
   logic        fl_prev = 1'b0;
   logic        ew_prev = 1'b1;
   logic [63:0] hold_data = '0;
   logic [198:0] hold_vec = '0;

   function automatic logic [63:0] ref_res(input logic [1:0] fp,
                                           input logic [4:0] alu,
                                           input logic [63:0] a, b, c);
      if (fp == 2'b11) return 64'd0;
      return (a + b) ^ (c >> alu) ^ 64'(fp);
   endfunction

   function automatic int ref_lat(input logic [1:0] fp, input logic [4:0] alu);
      if (fp == 2'b00 || fp == 2'b11) return 1;
      if (alu == 5'd12 || alu == 5'd13) return 12;
      return 2;
   endfunction

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   // Registered EXU stand-in: computes only while not waiting.
   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (!exu_wait)
         exu_out <= ref_res(exu_fp_ctrl, exu_alu_ctrl, exu_in1, exu_in2, exu_in3);
   end

   always @(posedge clk) begin
      if (rnd_rdy) begin
         #1 res_ready = ($urandom % 4) != 0;
      end
   end

   // Issue tracker: an accepted request pushes its expected response.
   always @(negedge clk) begin
      if (!rst && req_valid && req_ready) begin
         sb.push_back('{ref_res(req_fp_ctrl, req_alu_ctrl, req_in1, req_in2, req_in3),
                        ref_lat(req_fp_ctrl, req_alu_ctrl), cyc});
      end
   end

   // Monitor
   always @(negedge clk) begin
      if (rst) begin
         sb.delete();
         exp_cnt = '0;
         rv_prev = 1'b0;
         fl_prev = 1'b0;
         ew_prev = 1'b1;
      end else begin
         chk("op_count", op_count, exp_cnt);
         chk("exu_flush", exu_flush, flush_in);
         if (fl_prev) chk("flush_drop", res_valid, 1'b0);
         if (!exu_wait && !ew_prev)
            chk("exu_hold", 64'({exu_fp_ctrl, exu_alu_ctrl, exu_in1, exu_in2, exu_in3} == hold_vec), 64'd1);
         if (res_valid) begin
            chk("wait_done", exu_wait, 1'b1);
            chk("ready_done", req_ready, 1'b0);
            if (!rv_prev) begin
               if (sb.size() == 0) begin
                  total++; bad++;
                  $display("FAIL unexpected_result: got %0h want none", res_data);
               end else begin
                  chk("latency", 64'(cyc - sb[0].acc), 64'(sb[0].lat + 2));
               end
            end else begin
               chk("res_hold", res_data, hold_data);
            end
         end
         if (flush_in) begin
            sb.delete();
         end else if (res_valid && res_ready && sb.size() != 0) begin
            chk("res_data", res_data, sb[0].d);
            void'(sb.pop_front());
            exp_cnt = exp_cnt + 32'd1;
         end
         rv_prev   = res_valid && !res_ready && !flush_in;
         fl_prev   = flush_in;
         ew_prev   = exu_wait;
         hold_data = res_data;
         hold_vec  = {exu_fp_ctrl, exu_alu_ctrl, exu_in1, exu_in2, exu_in3};
      end
   end

   task automatic issue(input logic [1:0] fp, input logic [4:0] alu,
                        input logic [63:0] a, input logic [63:0] b, input logic [63:0] c);
      int n = 0;
      @(posedge clk); #1;
      req_valid = 1'b1;
      req_fp_ctrl = fp;
      req_alu_ctrl = alu;
      req_in1 = a;
      req_in2 = b;
      req_in3 = c;
      @(negedge clk);
      while (!req_ready && n < 300) begin
         @(negedge clk);
         n++;
      end
      if (!req_ready) begin
         total++; bad++;
         $display("FAIL issue_timeout: got ready=0 want ready=1");
      end
      @(posedge clk); #1 req_valid = 1'b0;
   endtask

   task automatic wait_rv();
      int n = 0;
      @(negedge clk);
      while (!res_valid && n < 100) begin
         @(negedge clk);
         n++;
      end
      if (!res_valid) begin
         total++; bad++;
         $display("FAIL rv_timeout: got res_valid=0 want 1");
      end
   endtask

   task automatic drain();
      int n = 0;
      while (sb.size() != 0 && n < 500) begin
         @(negedge clk);
         n++;
      end
      if (sb.size() != 0) begin
         total++; bad++;
         $display("FAIL drain_timeout: got %0d pending want 0", sb.size());
      end
      repeat (3) @(negedge clk);
   endtask

   initial begin
      repeat (3) @(negedge clk);
      chk("rst_res_valid", res_valid, 1'b0);
      chk("rst_res_data", res_data, 64'd0);
      chk("rst_op_count", op_count, 32'd0);
      chk("rst_exu_wait", exu_wait, 1'b1);
      chk("rst_exu_in1", exu_in1, 64'd0);
      #2 rst = 1'b0;
      @(negedge clk);
      chk("idle_ready", req_ready, 1'b1);

      // INT add, FP div, FP sqrt, FP add, illegal fp_ctrl
      res_ready = 1'b1;
      issue(2'b00, 5'd0, 64'd5, 64'd7, 64'd0);
      drain();
      chk("int_add_count", op_count, 32'd1);
      issue(2'b01, 5'd12, 64'd100, 64'd3, 64'hF0);
      drain();
      issue(2'b10, 5'd13, 64'd9, 64'd1, 64'd2);
      drain();
      issue(2'b01, 5'd3, 64'd11, 64'd22, 64'h33);
      drain();
      issue(2'b11, 5'd12, 64'hAAAA, 64'h5555, 64'd1);
      drain();

      // Backpressure with a pending request
      res_ready = 1'b0;
      issue(2'b00, 5'd1, 64'd40, 64'd2, 64'd0);
      wait_rv();
      @(posedge clk); #1;
      req_valid = 1'b1;
      req_fp_ctrl = 2'b01;
      repeat (5) begin
         @(negedge clk);
         chk("bp_ready", req_ready, 1'b0);
         chk("bp_valid", res_valid, 1'b1);
      end
      @(posedge clk); #1;
      req_valid = 1'b0;
      res_ready = 1'b1;
      drain();

      // Flush during FP div countdown
      issue(2'b01, 5'd12, 64'd1, 64'd2, 64'd3);
      repeat (5) @(posedge clk);
      #1 flush_in = 1'b1;
      @(negedge clk);
      chk("flush_ready", req_ready, 1'b0);
      @(posedge clk); #1 flush_in = 1'b0;
      @(negedge clk);
      chk("flush_idle", req_ready, 1'b1);
      chk("flush_wait", exu_wait, 1'b1);
      repeat (20) @(negedge clk);

      // Flush with a request in IDLE is not accepted
      @(posedge clk); #1;
      req_valid = 1'b1;
      flush_in = 1'b1;
      @(negedge clk);
      chk("flush_idle_ready", req_ready, 1'b0);
      @(posedge clk); #1;
      req_valid = 1'b0;
      flush_in = 1'b0;
      repeat (6) @(negedge clk);

      // Randomized traffic with random backpressure and flushes
      rnd_rdy = 1'b1;
      for (int i = 0; i < 40; i++) begin
         logic [4:0] alu;
         alu = (($urandom % 3) == 0) ? 5'(12 + ($urandom % 2)) : 5'($urandom % 32);
         issue(2'($urandom % 4), alu, {$urandom, $urandom}, {$urandom, $urandom},
               {$urandom, $urandom});
         if (($urandom % 6) == 0) begin
            repeat ($urandom_range(0, 15)) @(posedge clk);
            #1 flush_in = 1'b1;
            @(posedge clk); #1 flush_in = 1'b0;
         end
      end
      drain();
      rnd_rdy = 1'b0;
      @(posedge clk); #1 res_ready = 1'b0;

      // Async reset while a result is waiting
      issue(2'b10, 5'd4, 64'd8, 64'd8, 64'd0);
      wait_rv();
      #2 rst = 1'b1;
      #1;
      chk("arst_res_valid", res_valid, 1'b0);
      chk("arst_res_data", res_data, 64'd0);
      chk("arst_op_count", op_count, 32'd0);
      chk("arst_exu_wait", exu_wait, 1'b1);
      repeat (2) @(negedge clk);
      #2 rst = 1'b0;

      // op_count wrap
      @(negedge clk); #2;
      force dut.op_count_q = 32'hFFFF_FFFE;
      exp_cnt = 32'hFFFF_FFFE;
      #1 release dut.op_count_q;
      res_ready = 1'b1;
      issue(2'b00, 5'd2, 64'd1, 64'd1, 64'd0);
      drain();
      chk("wrap_ff", op_count, 32'hFFFF_FFFF);
      issue(2'b01, 5'd2, 64'd3, 64'd4, 64'd0);
      drain();
      chk("wrap_zero", op_count, 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL global_timeout: got running want finished");
      $fatal(1);
   end

endmodule
